jump_controller: RTL and testbench
==================================

# jump_controller

Sequences vertical motion for the player sprite. It turns a raw jump button and a ground-contact flag into rate-limited, one-cycle `jump` and `gravity_on` pulses that drive the player position register. It owns the airborne state machine, with phases for ascent, hang at apex and fall, and an internal step prescaler. It sits between the input synchroniser / collision logic and the player position datapath.

## Interface
- `TICK_DIV`, default 4: clocks per motion step; legal range ≥ 1.
- `JUMP_STEPS`, default 16: number of ascent steps per jump; legal range ≥ 1.
- `HANG_STEPS`, default 2: idle steps at apex; 0 skips the apex state.
- `clk` input, 1 bit: single system clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `jump_btn` input, 1 bit: synchronised jump button, level.
- `on_ground` input, 1 bit: player is standing on a surface.
- `jump` output, 1 bit: one-cycle pulse, move player up one jump increment.
- `gravity_on` output, 1 bit: one-cycle pulse, move player down one increment.
- `airborne` output, 1 bit: high in any state other than GROUNDED.
- `state` output, 2 bits: current FSM state, for debug.

## Operation
- Prescaler: counter runs 0..TICK_DIV-1 and wraps. `step` is true when the count equals TICK_DIV-1. With TICK_DIV=1, `step` is true every cycle.
- Press detect: `press = jump_btn & ~btn_q`. `btn_q` resets to 1, so a button held through reset never triggers a jump. It must be released and pressed again.
- Presses are never buffered. A press in a state that cannot accept it is discarded.
- States: GROUNDED=0, ASCEND=1, APEX=2, FALL=3.
- GROUNDED:
  - If `!on_ground`, go to FALL. This takes priority over a press in the same cycle.
  - Else if `press`, go to ASCEND and load `step_cnt = JUMP_STEPS`.
- ASCEND:
  - On each `step`, pulse `jump` and decrement `step_cnt`.
  - When the decrement reaches 0, go to APEX and load HANG_STEPS; if HANG_STEPS=0, go to FALL.
  - `on_ground` is ignored in this state.
- APEX:
  - On each `step`, decrement with no pulse.
  - At 0, go to FALL.
- FALL:
  - On `step` with `!on_ground`, pulse `gravity_on`.
  - When `on_ground`, go to GROUNDED. Landing is tested before `step`, so there is no gravity pulse in the landing cycle.
- `jump` and `gravity_on` are never high in the same cycle.
- Counter widths: `$clog2(max(JUMP_STEPS,HANG_STEPS)+1)` bits. The counter holds (never decrements) when not in ASCEND or APEX.

## Timing
- Reset values:
  - `state`: GROUNDED.
  - `jump`, `gravity_on`, `airborne`: 0.
  - Prescaler and `step_cnt`: 0.
  - `btn_q`: 1.
- Reset is asynchronous. Assertion clears everything immediately, including mid-ascent.
- All outputs are registered. A pulse appears in the clock cycle after the `step` cycle and lasts exactly 1 clk.
- Press to state change: the FSM leaves GROUNDED on the clock edge after the cycle in which `press` is high. The first `jump` pulse follows the next `step`.
- The prescaler free-runs and is never reset by a press, so the latency from press to the first pulse is 1..TICK_DIV+1 clks.
- Pulse spacing is exactly TICK_DIV clks.

## Configuration
- `JUMP_CTRL_DOUBLE_JUMP_EN` defined:
  - A one-bit `air_jump_avail` is set on entry to GROUNDED and at reset.
  - A `press` in APEX or FALL with `air_jump_avail=1` goes to ASCEND, reloads JUMP_STEPS and clears `air_jump_avail`.
  - A press in ASCEND is still ignored.
- `JUMP_CTRL_DOUBLE_JUMP_EN` undefined:
  - No `air_jump_avail` register exists.
  - All airborne presses are discarded.

## Structure
- Package `jump_ctrl_pkg` holds:
  - `typedef enum logic [1:0] jump_state_t` (GROUNDED, ASCEND, APEX, FALL).
  - Default parameter constants.
- Sub-module `step_prescaler` (parameter TICK_DIV; ports `clk`, `reset_n`, `step`) holds the free-running divider.
- The FSM, edge detect and pulse registers live in `jump_controller`.

## Test plan
All cases use TICK_DIV=4, JUMP_STEPS=16, HANG_STEPS=2 unless noted.
- Hold `jump_btn=1` through reset release with `on_ground=1` → no pulses and `state=0`. Release, then press → ASCEND.
- Press once with `on_ground=1` → exactly 16 `jump` pulses spaced 4 clks, then 8 clks with no pulse. Then `gravity_on` every 4 clks until `on_ground=1`, then `state=0` and `airborne=0`.
- Drop `on_ground` while GROUNDED, with a simultaneous press → FALL, 0 `jump` pulses, `gravity_on` at the next step.
- Press 3 extra times during ASCEND and FALL, macro undefined → still exactly 16 `jump` pulses total.
- With `JUMP_CTRL_DOUBLE_JUMP_EN`:
  - A press in FALL → 16 fresh `jump` pulses.
  - A further press in FALL → ignored.
  - After landing, the air jump is available again.
- Deassert `reset_n` after the 5th `jump` pulse → all outputs 0 within the same cycle, before any clock edge, and `state=0`.

Source files
------------

// File: rtl/jump_ctrl_pkg.sv
// Shared types and default constants for the player jump controller.
package jump_ctrl_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    ASCEND   = 2'd1,
    APEX     = 2'd2,
    FALL     = 2'd3
  } jump_state_t;

  localparam int DEF_TICK_DIV   = 4;
  localparam int DEF_JUMP_STEPS = 16;
  localparam int DEF_HANG_STEPS = 2;

  // Larger of two integers; sizes the shared ascent/hang step counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jump_ctrl_step_prescaler.sv
// Free-running motion-step divider: asserts step once every TICK_DIV clocks.
module step_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic step
);

  // A one-clock divider still needs a 1-bit counter to stay legal.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; never restarted by anything but reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign step = (count == LAST);

endmodule

// File: rtl/jump_controller.sv
// Player vertical-motion sequencer: turns a jump button and ground contact
// into rate-limited one-cycle jump / gravity_on pulses.
// Optional feature macro: JUMP_CTRL_DOUBLE_JUMP_EN (one mid-air jump per landing).
module jump_controller
  import jump_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int JUMP_STEPS = DEF_JUMP_STEPS,
  parameter int HANG_STEPS = DEF_HANG_STEPS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       jump_btn,
  input  logic       on_ground,
  output logic       jump,
  output logic       gravity_on,
  output logic       airborne,
  output logic [1:0] state
);

  localparam int CNT_MAX = max_int(JUMP_STEPS, HANG_STEPS);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_STEPS);
  localparam logic [CNT_W-1:0] HANG_LOAD = CNT_W'(HANG_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  jump_state_t      cur_state, nxt_state;
  logic [CNT_W-1:0] step_cnt, nxt_cnt;
  logic             btn_q;
  logic             press;
  logic             step;
  logic             nxt_jump, nxt_grav;
  logic             air_jump_req;

  step_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step)
  );

  // Rising-edge press detect; btn_q resets high so a button held through
  // reset must be released before it can trigger a jump.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= jump_btn;
    end
  end

  assign press = jump_btn & ~btn_q;

`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
  logic air_jump_avail;

  assign air_jump_req = press & air_jump_avail;

  // One air jump per landing: re-armed on entry to GROUNDED, spent when
  // an airborne press restarts the ascent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      air_jump_avail <= 1'b1;
    end else if (cur_state != GROUNDED && nxt_state == GROUNDED) begin
      air_jump_avail <= 1'b1;
    end else if ((cur_state == APEX || cur_state == FALL) && nxt_state == ASCEND) begin
      air_jump_avail <= 1'b0;
    end
  end
`else
  // Without the feature every airborne press is discarded.
  assign air_jump_req = 1'b0;
`endif

  // Next-state, step-counter and pulse decisions for the airborne FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    nxt_state = cur_state;
    nxt_cnt   = step_cnt;
    nxt_jump  = 1'b0;
    nxt_grav  = 1'b0;
    case (cur_state)
      GROUNDED: begin
        // Walking off a ledge wins over a simultaneous press.
        if (!on_ground) begin
          nxt_state = FALL;
        end else if (press) begin
          nxt_state = ASCEND;
          nxt_cnt   = JUMP_LOAD;
        end
      end
      ASCEND: begin
        // Ground contact and presses are both ignored while rising.
        if (step) begin
          nxt_jump = 1'b1;
          nxt_cnt  = step_cnt - 1'b1;
          if (step_cnt == CNT_ONE) begin
            if (HANG_STEPS == 0) begin
              nxt_state = FALL;
            end else begin
              nxt_state = APEX;
              nxt_cnt   = HANG_LOAD;
            end
          end
        end
      end
      APEX: begin
        if (air_jump_req) begin
          nxt_state = ASCEND;
          nxt_cnt   = JUMP_LOAD;
        end else if (step) begin
          nxt_cnt = step_cnt - 1'b1;
          if (step_cnt == CNT_ONE) begin
            nxt_state = FALL;
          end
        end
      end
      FALL: begin
        // Landing is tested first, so the landing cycle never pulses gravity.
        if (on_ground) begin
          nxt_state = GROUNDED;
        end else if (air_jump_req) begin
          nxt_state = ASCEND;
          nxt_cnt   = JUMP_LOAD;
        end else if (step) begin
          nxt_grav = 1'b1;
        end
      end
      default: begin
        nxt_state = GROUNDED;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= GROUNDED;
      step_cnt   <= '0;
      jump       <= 1'b0;
      gravity_on <= 1'b0;
      airborne   <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      step_cnt   <= nxt_cnt;
      jump       <= nxt_jump;
      gravity_on <= nxt_grav;
      airborne   <= (nxt_state != GROUNDED);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_jump_controller.sv
// Self-checking bench for jump_controller: directed scenarios followed by
// randomized button/ground activity, compared each cycle against a
// behavioural model built from the motion rules.
module tb_jump_controller;

  localparam int TD = 4;
  localparam int JS = 16;
  localparam int HS = 2;
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  // Model phases (numbered as the debug state port reports them).
  localparam int PH_GROUND = 0;
  localparam int PH_UP     = 1;
  localparam int PH_HANG   = 2;
  localparam int PH_FALL   = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       jump_btn;
  logic       on_ground;
  logic       jump;
  logic       gravity_on;
  logic       airborne;
  logic [1:0] state;

  jump_controller #(
    .TICK_DIV   (TD),
    .JUMP_STEPS (JS),
    .HANG_STEPS (HS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .jump_btn   (jump_btn),
    .on_ground  (on_ground),
    .jump       (jump),
    .gravity_on (gravity_on),
    .airborne   (airborne),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int m_cyc;      // clock edges since reset release (prescaler phase)
  int m_phase;
  int m_left;     // steps remaining in the current ascent or hang
  bit m_btn_prev;
  bit m_avail;
  bit e_jump, e_grav;

  // Observation bookkeeping.
  int cyc_now = 0;
  int jump_seen = 0;
  int grav_seen = 0;
  int first_grav_cyc = -1;
  int jump_times[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc      = 0;
    m_phase    = PH_GROUND;
    m_left     = 0;
    m_btn_prev = 1'b1;
    m_avail    = 1'b1;
    e_jump     = 1'b0;
    e_grav     = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs seen before it.
  task automatic model_edge(input bit btn, input bit gnd);
    bit stp, prs, air;
    stp = ((m_cyc % TD) == TD - 1);
    prs = btn && !m_btn_prev;
    air = DJ && prs && m_avail;
    e_jump = 1'b0;
    e_grav = 1'b0;
    if (m_phase == PH_GROUND) begin
      if (!gnd) m_phase = PH_FALL;
      else if (prs) begin m_phase = PH_UP; m_left = JS; end
    end else if (m_phase == PH_UP) begin
      if (stp) begin
        e_jump = 1'b1;
        m_left--;
        if (m_left == 0) begin
          if (HS > 0) begin m_phase = PH_HANG; m_left = HS; end
          else m_phase = PH_FALL;
        end
      end
    end else if (m_phase == PH_HANG) begin
      if (air) begin m_phase = PH_UP; m_left = JS; m_avail = 1'b0; end
      else if (stp) begin
        m_left--;
        if (m_left == 0) m_phase = PH_FALL;
      end
    end else begin
      if (gnd) begin m_phase = PH_GROUND; m_avail = 1'b1; end
      else if (air) begin m_phase = PH_UP; m_left = JS; m_avail = 1'b0; end
      else if (stp) e_grav = 1'b1;
    end
    m_btn_prev = btn;
    m_cyc++;
  endtask

  // Drive inputs, take one clock, then compare all outputs to the model.
  task automatic cycle(input bit btn, input bit gnd);
    jump_btn  = btn;
    on_ground = gnd;
    @(posedge clk);
    model_edge(btn, gnd);
    #1;
    cyc_now++;
    if (jump === 1'b1) begin
      jump_seen++;
      jump_times.push_back(cyc_now);
    end
    if (gravity_on === 1'b1) begin
      grav_seen++;
      if (first_grav_cyc < 0) first_grav_cyc = cyc_now;
    end
    check("jump", jump, e_jump);
    check("gravity_on", gravity_on, e_grav);
    check("airborne", airborne, (m_phase != PH_GROUND));
    check("state", state, m_phase);
  endtask

  task automatic clear_obs();
    jump_seen = 0;
    grav_seen = 0;
    first_grav_cyc = -1;
    jump_times.delete();
  endtask

  // Assert reset away from a clock edge, verify the asynchronous clear,
  // then release it away from an edge.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    check("rst_jump", jump, 1'b0);
    check("rst_gravity_on", gravity_on, 1'b0);
    check("rst_airborne", airborne, 1'b0);
    check("rst_state", state, 2'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    bit rb, rg;
    reset_n   = 1'b0;
    jump_btn  = 1'b1;
    on_ground = 1'b1;
    model_reset();

    // Reset state, button held high through reset release.
    #3;
    reset_pulse();
    repeat (12) cycle(1'b1, 1'b1);
    check("held_btn_no_jump", jump_seen, 0);
    check("held_btn_grounded", state, 2'd0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("press_to_ascend", state, 2'd1);

    // Full jump: 16 pulses spaced TD, hang, then gravity until landing.
    clear_obs();
    jump_seen = 1;            // the press cycle above can't pulse; start count fresh
    jump_seen = 0;
    repeat (100) cycle(1'b0, 1'b0);
    check("full_jump_count", jump_seen, JS);
    for (int i = 1; i < jump_times.size(); i++)
      check("jump_spacing", jump_times[i] - jump_times[i-1], TD);
    if (jump_times.size() > 0)
      check("apex_gap", first_grav_cyc - jump_times[jump_times.size()-1], (HS + 1) * TD);
    check("gravity_running", (grav_seen >= 4), 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    check("landed_state", state, 2'd0);
    check("landed_airborne", airborne, 1'b0);

    // Ledge drop with a simultaneous press: fall wins, no jump.
    cycle(1'b0, 1'b1);
    clear_obs();
    cycle(1'b1, 1'b0);
    check("ledge_fall_state", state, 2'd3);
    repeat (10) cycle(1'b0, 1'b0);
    check("ledge_no_jump", jump_seen, 0);
    check("ledge_gravity", (grav_seen >= 2), 1'b1);
    repeat (2) cycle(1'b0, 1'b1);

    // Extra presses in ascent and fall (one air jump when enabled).
    clear_obs();
    cycle(1'b1, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (60) cycle(1'b0, 1'b0);
    check("in_fall_before_press", state, 2'd3);
    cycle(1'b1, 1'b0);
    repeat (90) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (80) cycle(1'b0, 1'b0);
    check("extra_press_jumps", jump_seen, DJ ? 2 * JS : JS);
    repeat (3) cycle(1'b0, 1'b1);

    // Air jump re-armed after landing.
    clear_obs();
    cycle(1'b1, 1'b1);
    repeat (80) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (80) cycle(1'b0, 1'b0);
    check("rearmed_jumps", jump_seen, DJ ? 2 * JS : JS);
    repeat (3) cycle(1'b0, 1'b1);

    // Asynchronous reset right after the 5th jump pulse.
    cycle(1'b0, 1'b1);
    clear_obs();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 200 && jump_seen < 5; i++) cycle(1'b0, 1'b1);
    check("fifth_jump_reached", jump_seen, 5);
    check("fifth_jump_high", jump, 1'b1);
    reset_pulse();

    // Randomized button and ground activity.
    rb = 1'b0;
    rg = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      if ($urandom_range(0, 49) == 0) rg = ~rg;
      cycle(rb, rg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
